fpu_issue_ctrl: RTL and testbench

Issue/sequencing controller on the requester side of the combinational `fpu` block.
- Accepts one floating-point op at a time from decode via a valid/ready handshake, then latches operands, op code and destination register.
- Drives the `fpu` inputs stable for a per-op programmable number of cycles, so the multi-cycle path closes timing.
- Captures `fpu_result` and presents it to register-file writeback via a valid/ready handshake.

---
 rtl/fpu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - issue/sequencing controller in front of the combinational fpu
// Optional div-by-zero trap: FPU_ISSUE_DIVZ_TRAP_EN.
module fpu_issue_ctrl #(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [REG_W-1:0] req_rd,
  output logic [63:0]      fpu_operand1,
  output logic [63:0]      fpu_operand2,
  output logic [3:0]       fpu_op,
  input  logic [63:0]      fpu_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [REG_W-1:0] wb_rd,
  output logic [63:0]      wb_data,
  output logic             wb_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [63:0]      op1_q, op1_d, op2_q, op2_d, data_q, data_d;
  logic [3:0]       op_q, op_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             err_q, err_d;
  logic             skip_exec;

  function automatic logic [7:0] lat_m1(input logic [1:0] op);
    case (op)
      2'd2:    lat_m1 = 8'(MUL_LAT - 1);
      2'd3:    lat_m1 = 8'(DIV_LAT - 1);
      default: lat_m1 = 8'(ADD_LAT - 1);
    endcase
  endfunction

  // Ops that go straight to writeback with an error instead of issuing to the fpu.
`ifdef FPU_ISSUE_DIVZ_TRAP_EN
  assign skip_exec = (req_op > 4'd3) || ((req_op == 4'd3) && (req_b == 64'd0));
`else
  assign skip_exec = (req_op > 4'd3);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = skip_exec ? S_WB : S_EXEC;
      S_EXEC: if (cnt_q == 8'd0) state_d = S_WB;
      S_WB:   if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    wb_valid  = (state_q == S_WB);
  end

  always_comb begin
    cnt_d  = cnt_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    op_d   = op_q;
    rd_d   = rd_q;
    data_d = data_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op1_d = req_a;
          op2_d = req_b;
          op_d  = req_op;
          rd_d  = req_rd;
          if (skip_exec) begin
            data_d = 64'd0;
            err_d  = 1'b1;
          end else begin
            cnt_d = lat_m1(req_op[1:0]);
          end
        end
      end
      S_EXEC: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          data_d = fpu_result;
          err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= 8'd0;
      op1_q  <= 64'd0;
      op2_q  <= 64'd0;
      op_q   <= 4'd0;
      rd_q   <= '0;
      data_q <= 64'd0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      op_q   <= op_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign fpu_operand1 = op1_q;
  assign fpu_operand2 = op2_q;
  assign fpu_op       = op_q;
  assign wb_rd        = rd_q;
  assign wb_data      = data_q;
  assign wb_err       = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - randomized and directed checks of fpu_issue_ctrl against a timestamp model
module tb_fpu_issue_ctrl;
  localparam int REG_W   = 5;
  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = 4'd0;
  logic [63:0]      req_a = 64'd0, req_b = 64'd0;
  logic [REG_W-1:0] req_rd = '0;
  logic [63:0]      fpu_operand1, fpu_operand2, fpu_result;
  logic [3:0]       fpu_op;
  logic             wb_valid;
  logic             wb_ready = 1'b1;
  logic [REG_W-1:0] wb_rd;
  logic [63:0]      wb_data;
  logic             wb_err;
  logic             busy;

  fpu_issue_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_operand1(fpu_operand1), .fpu_operand2(fpu_operand2), .fpu_op(fpu_op),
    .fpu_result(fpu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational fpu: integer arithmetic is enough to tell results apart.
  function automatic logic [63:0] fpu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      default: return 64'h0BAD;
    endcase
  endfunction

  assign fpu_result = fpu_ref(fpu_op, fpu_operand1, fpu_operand2);

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd2) return MUL_LAT;
    if (op == 4'd3) return DIV_LAT;
    return ADD_LAT;
  endfunction

  function automatic bit is_trap(input logic [3:0] op, input logic [63:0] b);
`ifdef FPU_ISSUE_DIVZ_TRAP_EN
    return (op > 4'd3) || (op == 4'd3 && b == 64'd0);
`else
    return (op > 4'd3);
`endif
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: one op in flight, result visible from edge (accept + latency) until the handshake edge.
  int               cyc = 0;
  bit               m_inflight = 0;
  int               m_ready_at = 0;
  logic [63:0]      m_op1 = 0, m_op2 = 0, m_pend = 0, m_data = 0;
  logic [3:0]       m_op = 0;
  logic [REG_W-1:0] m_rd = 0;
  logic             m_pend_err = 0, m_err = 0;
  int               m_hs = 0, dut_hs = 0;

  always @(posedge clk) begin
    int c;
    c = cyc + 1;
    if (reset && wb_valid && wb_ready) dut_hs++;
    if (!reset) begin
      m_inflight = 0; m_op1 = 0; m_op2 = 0; m_op = 0; m_rd = 0; m_data = 0; m_err = 0;
    end else if (!m_inflight) begin
      if (req_valid) begin
        m_inflight = 1;
        m_op1 = req_a; m_op2 = req_b; m_op = req_op; m_rd = req_rd;
        if (is_trap(req_op, req_b)) begin
          m_ready_at = c; m_pend = 64'd0; m_pend_err = 1'b1;
        end else begin
          m_ready_at = c + lat_of(req_op);
          m_pend = fpu_ref(req_op, req_a, req_b); m_pend_err = 1'b0;
        end
      end
    end else if (cyc >= m_ready_at && wb_ready) begin
      m_inflight = 0;
      m_hs++;
    end
    cyc = c;
    if (m_inflight && cyc >= m_ready_at) begin
      m_data = m_pend;
      m_err  = m_pend_err;
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    exp_v = m_inflight && (cyc >= m_ready_at);
    chk("req_ready", req_ready, !m_inflight);
    chk("busy", busy, m_inflight);
    chk("wb_valid", wb_valid, exp_v);
    chk("fpu_operand1", fpu_operand1, m_op1);
    chk("fpu_operand2", fpu_operand2, m_op2);
    chk("fpu_op", fpu_op, m_op);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_data", wb_data, m_data);
    if (exp_v) chk("wb_err", wb_err, m_err);
  end

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [REG_W-1:0] rd);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("issue_ready", req_ready, 1);
    #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Returns at the first negedge with wb_valid high; k counts edges after the accept edge.
  task automatic expect_wb(input string name, input int exp_k, input logic [63:0] exp_data,
                           input logic exp_err, input logic [REG_W-1:0] exp_rd);
    int k;
    k = 0;
    @(negedge clk);
    while (!wb_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 64'(k), 64'(exp_k));
    chk({name, "_data"}, wb_data, exp_data);
    chk({name, "_err"}, wb_err, exp_err);
    chk({name, "_rd"}, wb_rd, exp_rd);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    #1 reset = 1'b1;

    // addf 5+7
    wb_ready = 1'b1;
    issue(4'd0, 64'd5, 64'd7, 5'd3);
    expect_wb("t1", 1, 64'd12, 1'b0, 5'd3);
    @(negedge clk);
    chk("t1_idle_after", req_ready, 1);

    // divf 100/4 with a competing request held during EXEC
    issue(4'd3, 64'd100, 64'd4, 5'd9);
    req_valid = 1'b1; req_op = 4'd0; req_a = 64'd1; req_b = 64'd1; req_rd = 5'd1;
    @(negedge clk);
    chk("t2_busy", busy, 1);
    chk("t2_req_ready", req_ready, 0);
    chk("t2_operand1", fpu_operand1, 64'd100);
    chk("t2_op", fpu_op, 4'd3);
    expect_wb("t2", 7, 64'd25, 1'b0, 5'd9);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t2_idle_after", req_ready, 1);

    // mulf 6*7 with writeback back-pressure
    wb_ready = 1'b0;
    issue(4'd2, 64'd6, 64'd7, 5'd17);
    expect_wb("t3", 3, 64'd42, 1'b0, 5'd17);
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_valid", wb_valid, 1);
      chk("t3_hold_data", wb_data, 64'd42);
    end
    #1 wb_ready = 1'b1;
    @(negedge clk);
    chk("t3_released", wb_valid, 0);
    chk("t3_req_ready", req_ready, 1);

    // illegal op, then subf
    issue(4'd9, 64'd1, 64'd2, 5'd4);
    expect_wb("t4_illegal", 0, 64'd0, 1'b1, 5'd4);
    issue(4'd1, 64'd10, 64'd3, 5'd5);
    expect_wb("t4_sub", 1, 64'd7, 1'b0, 5'd5);

    // reset in the 4th EXEC cycle of a divf
    issue(4'd3, 64'd100, 64'd4, 5'd6);
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_wb_valid", wb_valid, 0);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_operand1", fpu_operand1, 0);
    chk("t5_operand2", fpu_operand2, 0);
    chk("t5_op", fpu_op, 0);
    chk("t5_wb_data", wb_data, 0);
    chk("t5_wb_rd", wb_rd, 0);
    chk("t5_wb_err", wb_err, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= wb_valid;
    end
    chk("t5_no_wb", seen, 0);

    // divide by zero
    issue(4'd3, 64'd9, 64'd0, 5'd7);
`ifdef FPU_ISSUE_DIVZ_TRAP_EN
    expect_wb("t6_divz", 0, 64'd0, 1'b1, 5'd7);
`else
    expect_wb("t6_divz", 8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd7);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      reset     = ($urandom_range(0, 99) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      req_a     = 64'($urandom_range(0, 65535));
      req_b     = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, 65535));
      req_rd    = REG_W'($urandom);
      wb_ready  = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    #1;
    reset = 1'b1; req_valid = 1'b0; wb_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("handshake_count", 64'(dut_hs), 64'(m_hs));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
